// File: rtl/mdu_sched.sv
// Multiply/divide sequencer for the E stage. The result is computed at issue and parked in a
// shadow pair, then committed to HI/LO after a fixed busy latency unless a flush aborts it.
module mdu_sched #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;
    localparam logic [3:0] OpMflo  = 4'd8;

    localparam logic [CNT_W-1:0] MultCnt = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DivCnt  = CNT_W'(DIV_LAT - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      shadowHi, shadowLo;

    logic             accept, divByZero;
    logic [63:0]      prodS, prodU;
    logic [31:0]      divisor, absA, absB, quoU, remU, qMag, rMag, quoS, remS;
    logic [31:0]      resHi, resLo;
    logic [CNT_W-1:0] startCnt;

    assign accept = op_valid & ~busy & ~flush;
    assign stall  = op_valid & busy & ~flush;

    always_comb begin
        // Sign-extended 64-bit operands give the signed product in the low 64 bits.
        prodS     = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        prodU     = {32'd0, rs_val} * {32'd0, rt_val};
        divByZero = (rt_val == 32'd0);
        divisor   = divByZero ? 32'd1 : rt_val;
        quoU      = rs_val / divisor;
        remU      = rs_val % divisor;
        absA      = rs_val[31] ? -rs_val : rs_val;
        absB      = divByZero ? 32'd1 : (rt_val[31] ? -rt_val : rt_val);
        qMag      = absA / absB;
        rMag      = absA % absB;
        quoS      = (rs_val[31] ^ rt_val[31]) ? -qMag : qMag;
        remS      = rs_val[31] ? -rMag : rMag;

        // Divide by zero reloads the current HI/LO so the later commit is a no-op.
        resHi = hi;
        resLo = lo;
        case (op)
            OpMult:  {resHi, resLo} = prodS;
            OpMultu: {resHi, resLo} = prodU;
            OpDiv:   if (!divByZero) begin resHi = remS; resLo = quoS; end
            OpDivu:  if (!divByZero) begin resHi = remU; resLo = quoU; end
            default: ;
        endcase
        startCnt = (op == OpMult || op == OpMultu) ? MultCnt : DivCnt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= StIdle;
            cnt      <= '0;
            busy     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            shadowHi <= 32'd0;
            shadowLo <= 32'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        case (op)
                            OpMult, OpMultu, OpDiv, OpDivu: begin
                                shadowHi <= resHi;
                                shadowLo <= resLo;
                                cnt      <= startCnt;
                                busy     <= 1'b1;
                                state    <= StBusy;
                            end
                            OpMthi:  hi <= rs_val;
                            OpMtlo:  lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                StBusy: begin
                    // Flush beats a commit landing on the same edge.
                    if (flush) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        hi    <= shadowHi;
                        lo    <= shadowLo;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        mf_data = 32'd0;
        if (op == OpMfhi) mf_data = hi;
        else if (op == OpMflo) mf_data = lo;
    end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: latency, arithmetic, stall, flush and reset scenarios.
module tb_mdu_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_valid;
    logic [3:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        flush;
    logic        busy, stall;
    logic [31:0] hi, lo, mf_data;

    int tests = 0;
    int fails = 0;

    localparam logic [3:0] MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;

    mdu_sched #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op_valid (op_valid),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo),
        .mf_data  (mf_data)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        op_valid = v;
        op       = o;
        rs_val   = a;
        rt_val   = b;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        drive(1'b1, MFHI, 32'd0, 32'd0);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b want 0", stall); end
        tests++; if (hi !== 32'd0) begin fails++; $display("FAIL reset_hi: got %h want 0", hi); end
        tests++; if (lo !== 32'd0) begin fails++; $display("FAIL reset_lo: got %h want 0", lo); end
        tests++; if (mf_data !== 32'd0) begin fails++; $display("FAIL reset_mf: got %h want 0", mf_data); end
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_mult;
        int n = 0;
        drive(1'b1, MULT, 32'hFFFFFFFD, 32'd5);
        tick;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        while (busy === 1'b1 && n < 40) begin
            n++;
            tests++;
            if (hi !== 32'd0 || lo !== 32'd0) begin
                fails++; $display("FAIL mult_hold: got hi=%h lo=%h want 0/0", hi, lo);
            end
            tick;
        end
        tests++; if (n != 5) begin fails++; $display("FAIL mult_busy_len: got %0d want 5", n); end
        tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        tests++; if (lo !== 32'hFFFFFFF1) begin fails++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        drive(1'b1, DIVU, 32'd17, 32'd5);
        tick;
        drive(1'b1, MFLO, 32'd0, 32'd0);
        #1;
        while (stall === 1'b1 && n < 40) begin n++; tick; end
        tests++; if (n != 10) begin fails++; $display("FAIL divu_stall_len: got %0d want 10", n); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL divu_busy: got %0b want 0", busy); end
        tests++; if (mf_data !== 32'd3) begin fails++; $display("FAIL divu_mflo: got %h want 3", mf_data); end
        tests++; if (hi !== 32'd2) begin fails++; $display("FAIL divu_hi: got %h want 2", hi); end
        tick;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic test_div;
        int n = 0;
        drive(1'b1, DIV, 32'hFFFFFFF9, 32'd2);
        tick;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        while (busy === 1'b1 && n < 40) begin n++; tick; end
        tests++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        drive(1'b1, DIV, 32'h80000000, 32'hFFFFFFFF);
        tick;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; tick; end
        tests++; if (lo !== 32'h80000000) begin fails++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        tests++; if (hi !== 32'd0) begin fails++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
        drive(1'b1, MTHI, 32'h1234, 32'd0);
        tick;
        drive(1'b1, MTLO, 32'h5678, 32'd0);
        tick;
        drive(1'b1, DIV, 32'hFFFFFFF9, 32'd0);
        tick;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; tick; end
        tests++; if (n != 10) begin fails++; $display("FAIL div0_busy_len: got %0d want 10", n); end
        tests++; if (hi !== 32'h1234) begin fails++; $display("FAIL div0_hi: got %h want 1234", hi); end
        tests++; if (lo !== 32'h5678) begin fails++; $display("FAIL div0_lo: got %h want 5678", lo); end
    endtask

    task automatic test_flush;
        drive(1'b1, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        tick;
        tick;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush_pre_busy: got %0b want 1", busy); end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy: got %0b want 0", busy); end
        tests++; if (hi !== 32'h1234 || lo !== 32'h5678) begin
            fails++; $display("FAIL flush_hilo: got %h/%h want 1234/5678", hi, lo);
        end
        drive(1'b1, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (4) tick;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush2_pre_busy: got %0b want 1", busy); end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        tick;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush2_busy: got %0b want 0", busy); end
        tests++; if (hi !== 32'h1234 || lo !== 32'h5678) begin
            fails++; $display("FAIL flush2_hilo: got %h/%h want 1234/5678", hi, lo);
        end
        flush = 1'b1;
        drive(1'b1, MTHI, 32'hBAD, 32'd0);
        tick;
        flush = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        tests++; if (hi !== 32'h1234 || busy !== 1'b0) begin
            fails++; $display("FAIL flush_idle: got hi=%h busy=%0b want 1234/0", hi, busy);
        end
    endtask

    task automatic test_mt_mf;
        int n = 0;
        drive(1'b1, MTHI, 32'hA5A5A5A5, 32'd0);
        tick;
        drive(1'b1, MFHI, 32'd0, 32'd0);
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mfhi_stall: got %0b want 0", stall); end
        tests++; if (mf_data !== 32'hA5A5A5A5) begin fails++; $display("FAIL mfhi_data: got %h want a5a5a5a5", mf_data); end
        drive(1'b1, MULT, 32'd2, 32'd3);
        tick;
        drive(1'b1, MTLO, 32'hDEADBEEF, 32'd0);
        #1;
        while (stall === 1'b1 && n < 40) begin n++; tick; end
        tests++; if (n != 5) begin fails++; $display("FAIL mtlo_stall_len: got %0d want 5", n); end
        tests++; if (lo !== 32'd6 || hi !== 32'd0) begin
            fails++; $display("FAIL mtlo_commit: got %h/%h want 0/6", hi, lo);
        end
        tick;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        tests++; if (lo !== 32'hDEADBEEF) begin fails++; $display("FAIL mtlo_write: got %h want deadbeef", lo); end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        drive(1'b1, MTHI, 32'h77, 32'd0);
        tick;
        drive(1'b1, DIV, 32'd100, 32'd3);
        tick;
        drive(1'b1, MFHI, 32'd0, 32'd0);
        repeat (3) tick;
        tests++; if (stall !== 1'b1 || mf_data !== 32'h77) begin
            fails++; $display("FAIL rstmid_pre: got stall=%0b mf=%h want 1/77", stall, mf_data);
        end
        #3;
        reset_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || stall !== 1'b0) begin
            fails++; $display("FAIL rstmid_ctl: got busy=%0b stall=%0b want 0/0", busy, stall);
        end
        tests++; if (hi !== 32'd0 || lo !== 32'd0 || mf_data !== 32'd0) begin
            fails++; $display("FAIL rstmid_data: got %h/%h/%h want 0/0/0", hi, lo, mf_data);
        end
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, MULT, 32'd6, 32'd7);
        tick;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        while (busy === 1'b1 && n < 40) begin n++; tick; end
        tests++; if (lo !== 32'd42 || hi !== 32'd0) begin
            fails++; $display("FAIL rstmid_mult: got %h/%h want 0/2a", hi, lo);
        end
    endtask

    initial begin
        flush = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        reset_n = 1'b0;
        #12;
        test_reset;
        test_mult;
        test_back_to_back;
        test_div;
        test_flush;
        test_mt_mf;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
